audio_pwm_out: RTL and testbench
================================

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, meaning the PWM frame counter width (frame = 2^PWM_BITS clocks).
REQ-002 SHALL have parameter ENV_STEP_DIV, default 50000, meaning clocks per envelope step (1 ms at 50 MHz); legal range 2..65535.
REQ-003 SHALL have port clk50Mghz, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port sample, input, 4 bits: unsigned sine sample from the ROM stage (0..15).
REQ-006 SHALL have port note_on, input, 1 bit: high while any note key is held.
REQ-007 SHALL have port pwm_out, output, 1 bit: registered PWM audio output.
REQ-008 SHALL have port env_level, output, 4 bits: current envelope level (0..15).
REQ-009 SHALL have port busy, output, 1 bit: high whenever the envelope state is not IDLE.

Function
REQ-010 SHALL run a free-running PWM_BITS-bit frame counter, incrementing every clock and wrapping from all-ones to 0.
REQ-011 SHALL latch duty = sample * env_level (8-bit unsigned product, max 225) in the clock where the counter wraps to 0; the new duty applies from that frame's counter value 0.
REQ-012 SHALL drive pwm_out high in cycles where counter < latched duty, registered (one clock latency); duty 0 gives constant low.
REQ-013 SHALL implement envelope states IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-014 SHALL transition IDLE->ATTACK on the clock note_on is sampled high.
REQ-015 SHALL, in ATTACK, increment env_level by 1 on each step tick; on reaching 15, enter SUSTAIN.
REQ-016 SHALL hold env_level at 15 in SUSTAIN.
REQ-017 SHALL enter RELEASE from ATTACK or SUSTAIN when note_on is sampled low, keeping the current level.
REQ-018 SHALL, in RELEASE, decrement env_level by 1 per step tick; on reaching 0, enter IDLE.
REQ-019 SHALL re-enter ATTACK from RELEASE when note_on is sampled high, continuing upward from the current level.
REQ-020 SHALL produce a step tick every ENV_STEP_DIV clocks; the step counter SHALL clear on every state change, so the first step after a transition comes ENV_STEP_DIV clocks later.
REQ-021 SHALL never wrap env_level: it saturates at 15 and floors at 0.

Reset
REQ-022 SHALL, while rst is high, force: state IDLE, env_level 0, frame counter 0, step counter 0, latched duty 0, pwm_out 0, busy 0.
REQ-023 SHALL, when rst asserts mid-note, immediately silence pwm_out with no release ramp.

Configuration
REQ-024 SHALL honour macro AUDIO_ENV_EN: when defined, the envelope is as in REQ-013..REQ-021.
REQ-025 SHALL, when AUDIO_ENV_EN is not defined, omit the envelope logic: env_level = 15 when note_on is high, 0 otherwise (registered, one clock); busy = registered note_on; PWM behaviour is otherwise unchanged.

Structure
REQ-026 SHALL take the envelope state encoding (2-bit IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3) and the ENV_MAX=15 constant from shared package audio_pkg.
REQ-027 SHALL place the envelope state machine and step counter in sub-module env_gen; PWM counter, duty multiply and output register stay in audio_pwm_out.

Verification
REQ-028 Scenario: PWM_BITS=8, AUDIO_ENV_EN undefined, note_on=1, sample=15 -> duty 225; pwm_out high exactly 225 of every 256 clocks after the first full frame.
REQ-029 Scenario: ENV_STEP_DIV=4, AUDIO_ENV_EN defined, note_on rises at t0 -> env_level reaches 1 at t0+1+4 clocks, reaches 15 after 15 ticks (60 clocks), state SUSTAIN, busy=1.
REQ-030 Scenario: from SUSTAIN, note_on falls -> RELEASE; env_level reaches 0 after 60 clocks (ENV_STEP_DIV=4), then IDLE, busy=0, pwm_out constant low.
REQ-031 Scenario: note_on drops at env_level 6 during ATTACK, then rises at env_level 4 during RELEASE -> level resumes 5,6,... without a jump to 0 or 15.
REQ-032 Scenario: sample changes from 8 to 3 mid-frame at env_level 15 -> the current frame keeps duty 120; the next frame uses duty 45.
REQ-033 Scenario: rst asserted asynchronously during SUSTAIN with pwm_out high -> pwm_out, env_level and busy go to 0 before the next clock edge; after release, the block stays IDLE until note_on is high.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants for the audio PWM output path:
// envelope state encoding and the envelope ceiling.
package audio_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ATTACK  = 2'd1;
   localparam logic [1:0] ST_SUSTAIN = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   localparam logic [3:0] ENV_MAX = 4'd15;

endpackage

// File: rtl/audio_pwm_env_gen.sv
// env_gen: note envelope (ATTACK/SUSTAIN/RELEASE) and step timer.
// Optional feature macro: AUDIO_ENV_EN. Without it the level is a
// registered 0/15 gate that follows note_on.
// Ports: clk_s, rst (async, high), note_on -> env_level[3:0], busy.
module env_gen
   import audio_pkg::*;
#(
   parameter int unsigned ENV_STEP_DIV = 50000
) (
   input  logic       clk_s,
   input  logic       rst,
   input  logic       note_on,
   output logic [3:0] env_level,
   output logic       busy
);

   logic [3:0] level;

`ifdef AUDIO_ENV_EN

   logic [1:0]  state;
   logic [1:0]  state_nx;
   logic [3:0]  level_nx;
   logic [15:0] step_cnt;
   logic        tick;

   assign tick = (step_cnt == 16'(ENV_STEP_DIV - 1));

   always_comb begin
      state_nx = state;
      level_nx = level;
      case (state)
         ST_IDLE: begin
            if (note_on)
               state_nx = ST_ATTACK;
         end
         ST_ATTACK: begin
            if (!note_on) begin
               state_nx = ST_RELEASE;
            end else if (tick) begin
               // saturate at the ceiling and settle in SUSTAIN
               if (level >= ENV_MAX - 4'd1) begin
                  level_nx = ENV_MAX;
                  state_nx = ST_SUSTAIN;
               end else begin
                  level_nx = level + 4'd1;
               end
            end
         end
         ST_SUSTAIN: begin
            level_nx = ENV_MAX;
            if (!note_on)
               state_nx = ST_RELEASE;
         end
         default: begin
            if (note_on) begin
               state_nx = ST_ATTACK;
            end else if (tick) begin
               // floor at zero and fall back to IDLE
               if (level <= 4'd1) begin
                  level_nx = '0;
                  state_nx = ST_IDLE;
               end else begin
                  level_nx = level - 4'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_s or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         level <= '0;
      end else begin
         state <= state_nx;
         level <= level_nx;
      end
   end

   // restart the step interval on every state change so the first
   // step always lands a full interval after the transition
   always_ff @(posedge clk_s or posedge rst) begin
      if (rst)
         step_cnt <= '0;
      else if (state_nx != state || state == ST_IDLE || tick)
         step_cnt <= '0;
      else
         step_cnt <= step_cnt + 16'd1;
   end

   assign busy = (state != ST_IDLE);

`else

   logic busy_q;
   logic unused_div;

   assign unused_div = ^ENV_STEP_DIV;

   always_ff @(posedge clk_s or posedge rst) begin
      if (rst) begin
         level  <= '0;
         busy_q <= 1'b0;
      end else begin
         level  <= note_on ? ENV_MAX : 4'd0;
         busy_q <= note_on;
      end
   end

   assign busy = busy_q;

`endif

   assign env_level = level;

endmodule

// File: rtl/audio_pwm_out.sv
// Audio PWM output: frame counter, per-frame duty = sample * envelope,
// registered PWM compare. Envelope in env_gen (macro AUDIO_ENV_EN).
// Ports: clk50Mghz, rst (async, high), sample[3:0], note_on ->
//        pwm_out, env_level[3:0], busy.
module audio_pwm_out
   import audio_pkg::*;
#(
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned ENV_STEP_DIV = 50000
) (
   input  logic       clk50Mghz,
   input  logic       rst,
   input  logic [3:0] sample,
   input  logic       note_on,
   output logic       pwm_out,
   output logic [3:0] env_level,
   output logic       busy
);

   localparam int unsigned CW = (PWM_BITS > 8) ? PWM_BITS : 8;

   logic [PWM_BITS-1:0] frame_cnt;
   logic [7:0]          duty;
   logic [7:0]          product;
   logic                wrap;

   assign wrap    = &frame_cnt;
   assign product = {4'd0, sample} * {4'd0, env_level};

   env_gen #(
      .ENV_STEP_DIV (ENV_STEP_DIV)
   ) u_env (
      .clk_s     (clk50Mghz),
      .rst       (rst),
      .note_on   (note_on),
      .env_level (env_level),
      .busy      (busy)
   );

   // duty only changes on the edge that wraps the counter to 0,
   // so each frame plays one consistent duty
   always_ff @(posedge clk50Mghz or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         duty      <= '0;
         pwm_out   <= 1'b0;
      end else begin
         frame_cnt <= frame_cnt + 1'b1;
         if (wrap)
            duty <= product;
         pwm_out <= CW'(frame_cnt) < CW'(duty);
      end
   end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Bench for audio_pwm_out: vector table, corner sequences and
// randomized traffic against a frame-level reference model.
module tb_audio_pwm_out;

   localparam int DIV = 4;
   localparam int P_IDLE = 0;
   localparam int P_ATT  = 1;
   localparam int P_SUS  = 2;
   localparam int P_REL  = 3;

   logic       clk50Mghz = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sample = '0;
   logic       note_on = 1'b0;
   logic       pwm_out;
   logic [3:0] env_level;
   logic       busy;

   always #5 clk50Mghz = ~clk50Mghz;

   audio_pwm_out #(
      .PWM_BITS     (8),
      .ENV_STEP_DIV (DIV)
   ) dut (
      .clk50Mghz (clk50Mghz),
      .rst       (rst),
      .sample    (sample),
      .note_on   (note_on),
      .pwm_out   (pwm_out),
      .env_level (env_level),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int ones  = 0;

   int m_k, m_duty, m_pwm, m_env, m_busy, m_st, m_since;

   typedef struct {
      bit         n;
      logic [3:0] s;
      int         cycles;
      int         env;
      int         bsy;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)",
                  nm, act, exp, m_k);
      end
   endtask

   task automatic go(input int st);
      m_st    = st;
      m_since = 0;
   endtask

`ifdef AUDIO_ENV_EN
   task automatic env_rules(input bit n);
      m_since++;
      case (m_st)
         P_IDLE: if (n) go(P_ATT);
         P_ATT: begin
            if (!n) go(P_REL);
            else if (m_since == DIV) begin
               m_since = 0;
               m_env = (m_env >= 15) ? 15 : m_env + 1;
               if (m_env == 15) go(P_SUS);
            end
         end
         P_SUS: if (!n) go(P_REL);
         default: begin
            if (n) go(P_ATT);
            else if (m_since == DIV) begin
               m_since = 0;
               m_env = (m_env <= 0) ? 0 : m_env - 1;
               if (m_env == 0) go(P_IDLE);
            end
         end
      endcase
      m_busy = (m_st != P_IDLE) ? 1 : 0;
   endtask
`endif

   // one rising edge of the reference: output reflects the frame
   // position before the edge; a new duty is taken at position 255
   task automatic model_edge(input bit n, input int s);
      int pos;
      pos   = m_k % 256;
      m_pwm = (pos < m_duty) ? 1 : 0;
      if (pos == 255)
         m_duty = s * m_env;
`ifdef AUDIO_ENV_EN
      env_rules(n);
`else
      m_env  = n ? 15 : 0;
      m_busy = n ? 1 : 0;
`endif
      m_k++;
   endtask

   task automatic cyc(input bit n, input logic [3:0] s);
      note_on = n;
      sample  = s;
      @(posedge clk50Mghz);
      model_edge(n, int'(s));
      @(negedge clk50Mghz);
      ones += int'(pwm_out);
      chk("pwm", int'(pwm_out), m_pwm);
      chk("env", int'(env_level), m_env);
      chk("busy", int'(busy), m_busy);
   endtask

   task automatic do_reset();
      @(negedge clk50Mghz);
      rst     = 1'b1;
      note_on = 1'b0;
      sample  = '0;
      @(negedge clk50Mghz);
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_env", int'(env_level), 0);
      chk("rst_busy", int'(busy), 0);
      rst      = 1'b0;
      m_k      = 0;
      m_duty   = 0;
      m_pwm    = 0;
      m_env    = 0;
      m_busy   = 0;
      m_since  = 0;
      m_st     = P_IDLE;
   endtask

   task automatic align(input bit n, input logic [3:0] s);
      while (m_k % 256 != 0)
         cyc(n, s);
   endtask

   initial begin
      tbl[0] = '{1'b1, 4'd15, 70, 15, 1};
      tbl[1] = '{1'b1, 4'd7, 300, 15, 1};
      tbl[2] = '{1'b0, 4'd7, 70, 0, 0};
      tbl[3] = '{1'b1, 4'd0, 70, 15, 1};
      tbl[4] = '{1'b0, 4'd9, 70, 0, 0};
      tbl[5] = '{1'b1, 4'd4, 100, 15, 1};

      do_reset();

      for (int i = 0; i < 6; i++) begin
         repeat (tbl[i].cycles) cyc(tbl[i].n, tbl[i].s);
         chk($sformatf("vec%0d_env", i), int'(env_level), tbl[i].env);
         chk($sformatf("vec%0d_busy", i), int'(busy), tbl[i].bsy);
      end

      // envelope timing corners
      do_reset();
      repeat (3) cyc(1'b0, 4'd5);
`ifdef AUDIO_ENV_EN
      cyc(1'b1, 4'd5);
      repeat (3) begin
         cyc(1'b1, 4'd5);
         chk("att_wait", int'(env_level), 0);
      end
      cyc(1'b1, 4'd5);
      chk("att_first", int'(env_level), 1);
      repeat (56) cyc(1'b1, 4'd5);
      chk("att_top", int'(env_level), 15);
      chk("att_busy", int'(busy), 1);
      repeat (8) cyc(1'b1, 4'd5);
      chk("sus_hold", int'(env_level), 15);
      cyc(1'b0, 4'd5);
      repeat (59) cyc(1'b0, 4'd5);
      chk("rel_last", int'(env_level), 1);
      cyc(1'b0, 4'd5);
      chk("rel_zero", int'(env_level), 0);
      chk("rel_idle", int'(busy), 0);
      ones = 0;
      repeat (300) cyc(1'b0, 4'd5);
      chk("idle_silent", ones, 0);

      do_reset();
      cyc(1'b1, 4'd2);
      repeat (24) cyc(1'b1, 4'd2);
      chk("mid_att6", int'(env_level), 6);
      cyc(1'b0, 4'd2);
      repeat (8) cyc(1'b0, 4'd2);
      chk("mid_rel4", int'(env_level), 4);
      cyc(1'b1, 4'd2);
      repeat (3) cyc(1'b1, 4'd2);
      chk("resume4", int'(env_level), 4);
      cyc(1'b1, 4'd2);
      chk("resume5", int'(env_level), 5);
      repeat (4) cyc(1'b1, 4'd2);
      chk("resume6", int'(env_level), 6);
`else
      cyc(1'b1, 4'd5);
      chk("gate_on_env", int'(env_level), 15);
      chk("gate_on_busy", int'(busy), 1);
      cyc(1'b0, 4'd5);
      chk("gate_off_env", int'(env_level), 0);
      chk("gate_off_busy", int'(busy), 0);
`endif

      // full-scale duty over aligned frames
      do_reset();
      repeat (300) cyc(1'b1, 4'd15);
      align(1'b1, 4'd15);
      ones = 0;
      repeat (256) cyc(1'b1, 4'd15);
      chk("frame225_a", ones, 225);
      ones = 0;
      repeat (256) cyc(1'b1, 4'd15);
      chk("frame225_b", ones, 225);

      // sample change mid-frame takes effect next frame
      repeat (10) cyc(1'b1, 4'd8);
      align(1'b1, 4'd8);
      ones = 0;
      repeat (100) cyc(1'b1, 4'd8);
      repeat (156) cyc(1'b1, 4'd3);
      chk("frame120", ones, 120);
      ones = 0;
      repeat (256) cyc(1'b1, 4'd3);
      chk("frame45", ones, 45);

      // asynchronous reset while sounding
      repeat (10) cyc(1'b1, 4'd15);
      align(1'b1, 4'd15);
      repeat (5) cyc(1'b1, 4'd15);
      chk("pre_rst_pwm", int'(pwm_out), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_pwm", int'(pwm_out), 0);
      chk("async_env", int'(env_level), 0);
      chk("async_busy", int'(busy), 0);
      do_reset();
      ones = 0;
      repeat (40) cyc(1'b0, 4'd15);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_quiet", ones, 0);

      // randomized traffic
      do_reset();
      begin
         bit n = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0)
               n = ~n;
            cyc(n, 4'($urandom_range(0, 15)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
